// File: rtl/rv32i_multicycle_core_if.sv
// Single-port memory bus between the multicycle core (master) and unified memory (slave).
// A request is held with MemReq until the cycle MemReady is returned.
interface rv32i_multicycle_core_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [3:0]  ByteEnable;
  logic        MemWrite;
  logic        MemReq;
  logic        MemReady;
  logic [31:0] ReadData;

  modport master (
    output Address, WriteData, ByteEnable, MemWrite, MemReq,
    input  MemReady, ReadData
  );

  modport slave (
    input  Address, WriteData, ByteEnable, MemWrite, MemReq,
    output MemReady, ReadData
  );
endinterface

// File: rtl/rv32i_multicycle_core.sv
// Multicycle RV32I core: one instruction at a time over a single req/ready memory port,
// with byte/halfword load-store, redirect, and halt/fault stop states.
module rv32i_multicycle_core #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] REDIRECT_PC = 32'h0000_0018
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           redirect,
  rv32i_multicycle_core_if.master        bus,
  output logic                           retire,
  output logic                           halted,
  output logic                           fault
);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, instr, rs1_v, rs2_v, ea, load_q;
  logic        fault_q;
  logic [31:0] rf [0:31];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_opimm, is_op, is_sys, is_mem;
  assign is_lui   = (opcode == 7'b0110111);
  assign is_auipc = (opcode == 7'b0010111);
  assign is_jal   = (opcode == 7'b1101111);
  assign is_jalr  = (opcode == 7'b1100111);
  assign is_br    = (opcode == 7'b1100011);
  assign is_load  = (opcode == 7'b0000011);
  assign is_store = (opcode == 7'b0100011);
  assign is_opimm = (opcode == 7'b0010011);
  assign is_op    = (opcode == 7'b0110011);
  assign is_sys   = (opcode == 7'b1110011);
  assign is_mem   = is_load | is_store;

  // ALU with explicit signed views for SLT/SRA/BLT
  logic        [31:0] op_b, alu_y;
  logic signed [31:0] a_s, b_s, rs2_s;
  logic               br_taken;
  assign op_b  = is_op ? rs2_v : imm_i;
  assign a_s   = rs1_v;
  assign b_s   = op_b;
  assign rs2_s = rs2_v;

  always_comb begin
    alu_y = 32'b0;
    case (f3)
      3'b000:  alu_y = (is_op && instr[30]) ? rs1_v - op_b : rs1_v + op_b;
      3'b001:  alu_y = rs1_v << op_b[4:0];
      3'b010:  alu_y = {31'b0, a_s < b_s};
      3'b011:  alu_y = {31'b0, rs1_v < op_b};
      3'b100:  alu_y = rs1_v ^ op_b;
      3'b101:  alu_y = instr[30] ? a_s >>> op_b[4:0] : rs1_v >> op_b[4:0];
      3'b110:  alu_y = rs1_v | op_b;
      default: alu_y = rs1_v & op_b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000:  br_taken = (rs1_v == rs2_v);
      3'b001:  br_taken = (rs1_v != rs2_v);
      3'b100:  br_taken = (a_s < rs2_s);
      3'b101:  br_taken = (a_s >= rs2_s);
      3'b110:  br_taken = (rs1_v < rs2_v);
      3'b111:  br_taken = (rs1_v >= rs2_v);
      default: br_taken = 1'b0;
    endcase
  end

  logic [31:0] ea_next, pc_exec, exec_wd, jalr_t;
  logic        misaligned;
  assign ea_next    = rs1_v + (is_store ? imm_s : imm_i);
  assign misaligned = f3[1] ? (ea_next[1:0] != 2'b00) : (f3[0] & ea_next[0]);
  assign jalr_t     = (rs1_v + imm_i) & ~32'd1;

  always_comb begin
    pc_exec = pc + 32'd4;
    exec_wd = alu_y;
    if (is_lui)        exec_wd = imm_u;
    else if (is_auipc) exec_wd = pc + imm_u;
    else if (is_jal || is_jalr) exec_wd = pc + 32'd4;
    if (is_jal)                       pc_exec = pc + imm_j;
    else if (is_jalr)                 pc_exec = jalr_t;
    else if (is_br && br_taken)       pc_exec = pc + imm_b;
    else if (is_sys || (is_mem && misaligned)) pc_exec = pc;
  end

  // Load lane select and extension
  logic [31:0] rd_shift, load_ext;
  assign rd_shift = bus.ReadData >> {ea[1:0], 3'b000};
  always_comb begin
    case (f3)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {24'b0, rd_shift[7:0]};
      3'b101:  load_ext = {16'b0, rd_shift[15:0]};
      default: load_ext = bus.ReadData;
    endcase
  end

  logic        rf_we;
  logic [31:0] rf_wd;
  assign rf_we = !reset && !redirect && (rd != 5'd0) &&
                 ((state == EXECUTE && (is_lui || is_auipc || is_jal || is_jalr || is_op || is_opimm))
                  || state == WB);
  assign rf_wd = (state == WB) ? load_q : exec_wd;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else if (redirect) state <= FETCH;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (bus.MemReady) state_next = DECODE;
      DECODE:  state_next = EXECUTE;
      EXECUTE: begin
        if (is_sys || (is_mem && misaligned)) state_next = HALT;
        else if (is_mem) state_next = MEM;
        else state_next = FETCH;
      end
      MEM:     if (bus.MemReady) state_next = is_store ? FETCH : WB;
      WB:      state_next = FETCH;
      default: state_next = HALT;
    endcase
  end

  always_comb begin
    bus.MemReq     = (state == FETCH) || (state == MEM);
    bus.MemWrite   = (state == MEM) && is_store;
    bus.Address    = (state == MEM) ? {ea[31:2], 2'b00} : pc;
    bus.ByteEnable = 4'b1111;
    if (state == MEM && is_store) begin
      case (f3[1:0])
        2'b00:   bus.ByteEnable = 4'b0001 << ea[1:0];
        2'b01:   bus.ByteEnable = 4'b0011 << ea[1:0];
        default: bus.ByteEnable = 4'b1111;
      endcase
    end
    case (f3[1:0])
      2'b00:   bus.WriteData = {4{rs2_v[7:0]}};
      2'b01:   bus.WriteData = {2{rs2_v[15:0]}};
      default: bus.WriteData = rs2_v;
    endcase
    retire = !reset && !redirect &&
             ((state == EXECUTE && !is_mem && !is_sys) ||
              (state == MEM && is_store && bus.MemReady) ||
              (state == WB));
    halted = (state == HALT) && !fault_q;
    fault  = (state == HALT) && fault_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      fault_q <= 1'b0;
    end else if (redirect) begin
      pc      <= REDIRECT_PC;
      fault_q <= 1'b0;
    end else if (state == EXECUTE) begin
      pc      <= pc_exec;
      fault_q <= is_mem && misaligned;
    end
  end

  // Datapath registers and register file carry no reset
  always_ff @(posedge clk) begin
    if (state == FETCH && bus.MemReady) instr <= bus.ReadData;
    if (state == DECODE) begin
      rs1_v <= (rs1 == 5'd0) ? 32'b0 : rf[rs1];
      rs2_v <= (rs2 == 5'd0) ? 32'b0 : rf[rs2];
    end
    if (state == EXECUTE) ea <= ea_next;
    if (state == MEM && bus.MemReady) load_q <= load_ext;
    if (rf_we) rf[rd] <= rf_wd;
  end
endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// Scoreboarded bench for rv32i_multicycle_core: directed programs, expected stores queued,
// a bus monitor pops and compares each accepted store.
module tb_rv32i_multicycle_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic redirect = 1'b0;
  logic retire, halted, fault;

  rv32i_multicycle_core_if bus();

  rv32i_multicycle_core #(.RESET_PC(32'h0000_0000), .REDIRECT_PC(32'h0000_0018)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .bus(bus),
    .retire(retire), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } st_t;
  st_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int ws = 0;
  int wait_cnt = 0;
  int cyc = 0;
  int ret_cyc[$];
  logic stab_en = 1'b0;

  logic [31:0] img [0:255];
  logic [31:0] mem [0:255];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = 8'd0;
  logic [31:0] ld_data = 32'd0;

  assign bus.MemReady = bus.MemReq && (wait_cnt >= ws);
  assign bus.ReadData = mem[bus.Address[9:2]];

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.MemReq && bus.MemReady && bus.MemWrite)
      for (int k = 0; k < 4; k++)
        if (bus.ByteEnable[k]) mem[bus.Address[9:2]][8*k +: 8] <= bus.WriteData[8*k +: 8];
    if (reset || !bus.MemReq || bus.MemReady) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Store monitor and retire timestamping
  always @(negedge clk) begin : monitor
    st_t e;
    cyc <= cyc + 1;
    if (retire) ret_cyc.push_back(cyc);
    if (!reset && bus.MemReq && bus.MemReady && bus.MemWrite) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_store: addr 0x%08h data 0x%08h, expected no store", bus.Address, bus.WriteData);
      end else begin
        e = exp_q.pop_front();
        check("store_addr", bus.Address, e.addr);
        check("store_be", {28'b0, bus.ByteEnable}, {28'b0, e.be});
        check("store_data", bus.WriteData & lane_mask(e.be), e.data & lane_mask(e.be));
      end
    end
  end

  // Request attributes must hold while a request waits
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_wd = 32'd0;
  logic [3:0]  prev_be = 4'd0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    if (stab_en && prev_wait) begin
      check("wait_memreq", {31'b0, bus.MemReq}, 32'd1);
      check("wait_addr", bus.Address, prev_addr);
      check("wait_be", {28'b0, bus.ByteEnable}, {28'b0, prev_be});
      check("wait_we", {31'b0, bus.MemWrite}, {31'b0, prev_we});
      if (prev_we) check("wait_wdata", bus.WriteData, prev_wd);
    end
    prev_wait <= stab_en && !reset && !redirect && bus.MemReq && !bus.MemReady;
    prev_addr <= bus.Address;
    prev_wd   <= bus.WriteData;
    prev_be   <= bus.ByteEnable;
    prev_we   <= bus.MemWrite;
  end

  function automatic logic [31:0] i_type(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    logic [31:0] im, a, f, d;
    im = imm; a = rs1; f = f3; d = rd;
    return {im[11:0], a[4:0], f[2:0], d[4:0], op};
  endfunction
  function automatic logic [31:0] s_type(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] im, b, a, f;
    im = imm; b = rs2; a = rs1; f = f3;
    return {im[11:5], b[4:0], a[4:0], f[2:0], im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return i_type(imm, rs1, 0, rd, OPIMM);
  endfunction
  function automatic logic [31:0] sw_(input int rs2, input int rs1, input int imm);
    return s_type(imm, rs2, rs1, 2);
  endfunction

  function automatic st_t st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    st_t s;
    s.addr = a; s.be = be; s.data = d;
    return s;
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 32'd0;
  endtask

  // Loads the image under reset, checks reset outputs, then releases reset on a negedge
  task automatic start(input int w);
    @(negedge clk);
    reset = 1'b1;
    redirect = 1'b0;
    ws = w;
    for (int i = 0; i < 256; i++) begin
      ld_addr = i[7:0];
      ld_data = img[i];
      ld_en = 1'b1;
      @(negedge clk);
    end
    ld_en = 1'b0;
    check("rst_memreq", {31'b0, bus.MemReq}, 32'd1);
    check("rst_addr", bus.Address, 32'h0);
    check("rst_be", {28'b0, bus.ByteEnable}, 32'hF);
    check("rst_memwrite", {31'b0, bus.MemWrite}, 32'd0);
    check("rst_retire", {31'b0, retire}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic run_until_stop(input int max_cyc, input string name);
    int k;
    k = 0;
    while (!(halted || fault) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check({name, "_stopped"}, {31'b0, halted | fault}, 32'd1);
  endtask

  int r0, n0;

  initial begin
    // ALU sequence, zero wait states
    clear_img();
    img[0] = addi(1, 0, 5);
    img[1] = addi(2, 1, -7);
    img[2] = {7'b0, 5'd2, 5'd1, 3'b011, 5'd3, 7'b0110011};
    img[3] = sw_(1, 0, 32'h200);
    img[4] = sw_(2, 0, 32'h204);
    img[5] = sw_(3, 0, 32'h208);
    img[6] = EBREAK;
    exp_q.push_back(st(32'h200, 4'hF, 32'h0000_0005));
    exp_q.push_back(st(32'h204, 4'hF, 32'hFFFF_FFFE));
    exp_q.push_back(st(32'h208, 4'hF, 32'h0000_0001));
    start(0);
    r0 = ret_cyc.size();
    run_until_stop(200, "alu");
    check("alu_halted", {31'b0, halted}, 32'd1);
    check("alu_retires", ret_cyc.size() - r0, 32'd6);
    if (ret_cyc.size() >= r0 + 4) begin
      check("alu_lat1", ret_cyc[r0+1] - ret_cyc[r0], 32'd3);
      check("alu_lat2", ret_cyc[r0+2] - ret_cyc[r0+1], 32'd3);
      check("store_lat", ret_cyc[r0+3] - ret_cyc[r0+2], 32'd4);
    end
    check("alu_drain", exp_q.size(), 32'd0);

    // Byte/halfword stores and loads
    clear_img();
    img[0]  = addi(5, 0, 32'h100);
    img[1]  = {20'h89ABD, 5'd6, 7'b0110111};
    img[2]  = addi(6, 6, -529);
    img[3]  = s_type(1, 6, 5, 0);
    img[4]  = i_type(1, 5, 0, 7, 7'b0000011);
    img[5]  = i_type(1, 5, 4, 8, 7'b0000011);
    img[6]  = s_type(2, 6, 5, 1);
    img[7]  = i_type(2, 5, 1, 9, 7'b0000011);
    img[8]  = i_type(2, 5, 5, 10, 7'b0000011);
    img[9]  = sw_(7, 0, 32'h200);
    img[10] = sw_(8, 0, 32'h204);
    img[11] = sw_(9, 0, 32'h208);
    img[12] = sw_(10, 0, 32'h20C);
    img[13] = i_type(0, 5, 2, 11, 7'b0000011);
    img[14] = sw_(11, 0, 32'h210);
    img[15] = EBREAK;
    exp_q.push_back(st(32'h100, 4'b0010, 32'h0000_EF00));
    exp_q.push_back(st(32'h100, 4'b1100, 32'hCDEF_0000));
    exp_q.push_back(st(32'h200, 4'hF, 32'hFFFF_FFEF));
    exp_q.push_back(st(32'h204, 4'hF, 32'h0000_00EF));
    exp_q.push_back(st(32'h208, 4'hF, 32'hFFFF_CDEF));
    exp_q.push_back(st(32'h20C, 4'hF, 32'h0000_CDEF));
    exp_q.push_back(st(32'h210, 4'hF, 32'hCDEF_EF00));
    start(0);
    run_until_stop(400, "bytehalf");
    check("bytehalf_drain", exp_q.size(), 32'd0);

    // Three wait states on every request
    clear_img();
    img[0] = addi(5, 0, 32'h100);
    img[1] = i_type(0, 5, 2, 1, 7'b0000011);
    img[2] = sw_(1, 0, 32'h200);
    img[3] = EBREAK;
    img[64] = 32'h1234_5678;
    exp_q.push_back(st(32'h200, 4'hF, 32'h1234_5678));
    start(3);
    stab_en = 1'b1;
    r0 = ret_cyc.size();
    run_until_stop(400, "wait");
    stab_en = 1'b0;
    if (ret_cyc.size() >= r0 + 2)
      check("load_lat_ws3", ret_cyc[r0+1] - ret_cyc[r0], 32'd11);
    check("wait_retires", ret_cyc.size() - r0, 32'd3);
    check("wait_drain", exp_q.size(), 32'd0);

    // Redirect during a waiting fetch
    clear_img();
    img[0] = sw_(0, 0, 32'h240);
    img[6] = addi(2, 0, 32'h77);
    img[7] = sw_(2, 0, 32'h200);
    img[8] = EBREAK;
    exp_q.push_back(st(32'h200, 4'hF, 32'h0000_0077));
    start(3);
    r0 = ret_cyc.size();
    @(negedge clk);
    redirect = 1'b1;
    check("redir_cycle_retire", {31'b0, retire}, 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    check("redir_addr", bus.Address, 32'h18);
    check("redir_memreq", {31'b0, bus.MemReq}, 32'd1);
    check("redir_retire", {31'b0, retire}, 32'd0);
    run_until_stop(200, "redir");
    check("redir_retires", ret_cyc.size() - r0, 32'd2);
    check("redir_drain", exp_q.size(), 32'd0);

    // Misaligned word load faults; redirect recovers
    clear_img();
    img[0] = addi(1, 0, 32'h55);
    img[1] = i_type(2, 0, 2, 1, 7'b0000011);
    img[6] = sw_(1, 0, 32'h200);
    img[7] = EBREAK;
    exp_q.push_back(st(32'h200, 4'hF, 32'h0000_0055));
    start(0);
    r0 = ret_cyc.size();
    run_until_stop(100, "misal");
    check("misal_fault", {31'b0, fault}, 32'd1);
    check("misal_halted", {31'b0, halted}, 32'd0);
    check("misal_memreq", {31'b0, bus.MemReq}, 32'd0);
    repeat (4) @(negedge clk);
    check("misal_hold", {31'b0, fault}, 32'd1);
    check("misal_retires", ret_cyc.size() - r0, 32'd1);
    redirect = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    check("misal_cleared", {31'b0, fault}, 32'd0);
    check("misal_redir_addr", bus.Address, 32'h18);
    run_until_stop(100, "misal_post");
    check("misal_post_halted", {31'b0, halted}, 32'd1);
    check("misal_drain", exp_q.size(), 32'd0);

    // EBREAK timing, then synchronous reset
    clear_img();
    img[0] = EBREAK;
    start(0);
    n0 = ret_cyc.size();
    repeat (2) @(negedge clk);
    check("ebreak_early", {31'b0, halted}, 32'd0);
    @(negedge clk);
    check("ebreak_halted", {31'b0, halted}, 32'd1);
    check("ebreak_memreq", {31'b0, bus.MemReq}, 32'd0);
    check("ebreak_fault", {31'b0, fault}, 32'd0);
    check("ebreak_no_retire", ret_cyc.size() - n0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_addr", bus.Address, 32'h0);
    check("post_rst_halted", {31'b0, halted}, 32'd0);
    check("post_rst_memreq", {31'b0, bus.MemReq}, 32'd1);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32i_multicycle_core.md
# rv32i_multicycle_core

Second-generation multicycle RV32I core for the single-port instruction/data memory system. It generalises the first core in four ways: parametrised reset and redirect vectors, a req/ready memory handshake with arbitrary wait states, full byte/halfword load-store support with byte enables, and explicit halt/fault reporting for SYSTEM and misaligned accesses. It sits between the top level and the unified memory, and executes one instruction at a time.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- REDIRECT_PC, 32'h0000_0018, PC value loaded when `redirect` is asserted
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- redirect  in  1  synchronous; forces `PC <= REDIRECT_PC` and restarts fetch
- Address  out  32  memory byte address; always word-aligned (bits [1:0] = 0)
- WriteData  out  32  store data, with the byte/halfword replicated into the selected lanes
- ByteEnable  out  4  active lanes for a store; 4'b1111 for fetch and loads
- MemWrite  out  1  high for a store request only
- MemReq  out  1  access request; held high until accepted
- MemReady  in  1  memory accepts the request this cycle; ReadData is valid in the same cycle
- ReadData  in  32  read data
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  core stopped on ECALL/EBREAK
- fault  out  1  core stopped on a misaligned load/store

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- **FETCH**
  - MemReq=1, Address=PC, MemWrite=0.
  - On MemReady: latch `instr <= ReadData`, go to DECODE.
- **DECODE**
  - Read rs1/rs2; register x0 always reads 0.
  - Go to EXECUTE.
- **EXECUTE**
  - ALU, LUI, AUIPC, JAL and JALR write rd and update PC, then go to FETCH with a retire pulse.
  - Branch updates PC only, then FETCH with a retire pulse.
  - Load/store: compute ea = rs1 + imm. If misaligned, go to HALT with fault=1 and leave PC unchanged. Otherwise set PC <= PC+4 and go to MEM.
  - SYSTEM: go to HALT with halted=1 and leave PC unchanged.
- **MEM**
  - MemReq=1, Address={ea[31:2],2'b00}.
  - Store: MemWrite=1, ByteEnable from funct3 and ea[1:0]. SB gives 4'b0001<<ea[1:0]; SH gives 4'b0011<<ea[1:0]; SW gives 4'b1111.
  - Store on MemReady: go to FETCH with a retire pulse.
  - Load on MemReady: latch the lane-selected, extended data, then go to WB.
  - Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- **WB**
  - Write the load result to rd, go to FETCH, pulse retire.
- **Register writes**
  - A write to x0 is discarded.
  - The register file is not reset.
- **Misalignment**
  - Halfword access with ea[0]=1 is misaligned.
  - Word access with ea[1:0]≠0 is misaligned.
- **JALR target:** (rs1+imm) & ~1.
- **HALT:** MemReq=0. The core leaves HALT only on reset or redirect.
- **Arithmetic:** 32-bit wraparound. Shift amount is taken from bits [4:0]. SLT is signed and SLTU unsigned, with the same semantics as the first core.

## Timing
- **Reset values:**
  - state FETCH, PC=RESET_PC.
  - MemWrite=0, ByteEnable=4'b1111, retire=0, halted=0, fault=0.
  - MemReq=1 (the core is in FETCH).
  - Address=RESET_PC.
- **Priority:** reset > redirect > normal operation.
- **Redirect, in any state including HALT and mid-handshake:**
  - Next cycle: state FETCH, PC=REDIRECT_PC, halted/fault cleared.
  - A pending access is abandoned, even if MemReady arrives in the same cycle.
  - No register write and no retire occur in that cycle.
- **Reset mid-operation** behaves the same way, but loads RESET_PC.
- **Memory handshake:**
  - Address, WriteData, ByteEnable and MemWrite are stable while MemReq=1 and MemReady=0.
  - A request completes in the cycle MemReady=1.
  - MemReady while MemReq=0 is ignored.
- **Latency with zero wait states (MemReady tied high):**
  - ALU/branch/jump: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait state adds 1 cycle.
- **retire:** exactly one cycle per completed instruction. Never asserted for faulted or halted instructions.

## Test plan
- **ALU sequence, MemReady=1:** program `addi x1,x0,5; addi x2,x1,-7; sltu x3,x1,x2` -> x1=5, x2=0xFFFFFFFE, x3=1; retire pulses every 3 cycles.
- **Byte/halfword store and load:** x5=0x100, x6=0x89AB_CDEF. `sb x6,1(x5)` -> ByteEnable=4'b0010, WriteData[15:8]=0xEF. Then `lb x7,1(x5)` -> x7=0xFFFF_FFEF; `lbu` gives 0x0000_00EF; `sh` at offset 2 gives ByteEnable=4'b1100.
- **Wait states:** MemReady low for 3 cycles on each request. Address and MemReq stay stable while waiting; the `lw` result is unchanged; load latency becomes 5+6 cycles.
- **Redirect mid-fetch:** pulse redirect during the FETCH wait -> next cycle Address=0x18, MemReq=1, no retire; the instruction at 0x18 executes next.
- **Misaligned access:** `lw x1,2(x0)` -> fault=1, MemReq=0, x1 unchanged, PC stays at the faulting instruction. Redirect clears fault.
- **EBREAK:** halted=1 two cycles after fetch acceptance; then synchronous reset -> PC=RESET_PC, halted=0, MemReq=1.
